// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: shares one letter decoder across DIGITS
// positions, with frame-aligned atomic message update and optional left scroll.
module seg_scan_ctrl #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 1,
  parameter int SCROLL_DIV = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  msg_valid,
  input  logic [3*DIGITS-1:0]   msg_data,
  output logic                  msg_ready,
  input  logic                  scroll_en,
  output logic [2:0]            code_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DW:0] DIG_LIM = (DW+1)'(DIGITS);

  logic [CW-1:0] scan_cnt;
  logic [DW-1:0] digit;
  logic [DW-1:0] offset;
  logic [FW-1:0] frame_cnt;
  logic          pending;
  logic [2:0]    active [DIGITS];
  logic [2:0]    shadow [DIGITS];

  logic              slot_end;
  logic              boundary;
  logic              xfer;
  logic              pend_nxt;
  logic [DW:0]       sum;
  logic [DW-1:0]     sel;
  logic [DIGITS-1:0] an_nxt;

  // Slot/frame edge detection, handshake and next pending flag
  always_comb begin
    slot_end = (scan_cnt == CW'(SCAN_DIV - 1));
    boundary = slot_end && (digit == DW'(DIGITS - 1));
    xfer     = msg_valid && msg_ready;
    if (xfer) begin
      pend_nxt = 1'b1;
    end else if (boundary) begin
      pend_nxt = 1'b0;
    end else begin
      pend_nxt = pending;
    end
  end

  // Rotated buffer index (compare-and-wrap keeps non-power-of-two DIGITS legal)
  always_comb begin
    sum = {1'b0, digit} + {1'b0, offset};
    if (sum >= DIG_LIM) begin
      sel = DW'(sum - DIG_LIM);
    end else begin
      sel = DW'(sum);
    end
    an_nxt = '1;
    if (scan_cnt >= CW'(BLANK_CYC)) begin
      an_nxt[digit] = 1'b0;
    end else begin
      an_nxt = '1;
    end
  end

  // State registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      digit       <= '0;
      offset      <= '0;
      frame_cnt   <= '0;
      pending     <= 1'b0;
      msg_ready   <= 1'b1;
      code_out    <= 3'b000;
      an_out      <= '1;
      frame_start <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        active[i] <= 3'b000;
        shadow[i] <= 3'b000;
      end
    end else begin
      scan_cnt <= slot_end ? '0 : scan_cnt + CW'(1);
      if (slot_end) begin
        digit <= (digit == DW'(DIGITS - 1)) ? '0 : digit + DW'(1);
      end

      // A pending commit wins over scrolling; with scroll off the frame count idles at 0
      if (boundary && pending) begin
        for (int i = 0; i < DIGITS; i++) begin
          active[i] <= shadow[i];
        end
        offset    <= '0;
        frame_cnt <= '0;
      end else if (!scroll_en) begin
        frame_cnt <= '0;
      end else if (boundary) begin
        if (frame_cnt == FW'(SCROLL_DIV - 1)) begin
          offset    <= (offset == DW'(DIGITS - 1)) ? '0 : offset + DW'(1);
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      if (xfer) begin
        for (int i = 0; i < DIGITS; i++) begin
          shadow[i] <= msg_data[3*i +: 3];
        end
      end

      pending     <= pend_nxt;
      msg_ready   <= !pend_nxt;
      code_out    <= active[sel];
      an_out      <= an_nxt;
      frame_start <= boundary;
    end
  end

endmodule
